// File: rtl/mode_hub.sv
// mode_hub: selects the active display/function channel from three sources
// (hardware switches, UART commands, auto-scroll), routes button pulses and
// display data for that channel, and generates sensor start and soft-reset
// pulses.
//
// UART handshake: rx_data is only meaningful in a cycle where rx_done is 1.
// There is no back-pressure, so every byte qualified by rx_done is consumed
// in that same cycle.
//
// The source FSM state is exposed directly on o_src (00 SW, 01 UART, 10 AUTO).
module mode_hub #(
    parameter int N_CH     = 4,
    parameter int DATA_W   = 24,
    parameter int BTN_W    = 4,
    parameter int AUTO_CYC = 300_000_000,
    parameter int TRIG_CYC = 100_000_000,
    parameter logic [N_CH-1:0] TRIG_MASK = 4'b1100,
    parameter int SRST_CYC = 16,
    localparam int CW = $clog2(N_CH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [CW-1:0]            i_sw_mode,
    input  logic                     i_sw_auto,
    input  logic [BTN_W-1:0]         i_btn,
    input  logic                     rx_done,
    input  logic [7:0]               rx_data,
    input  logic [N_CH*DATA_W-1:0]   i_ch_data,
    output logic [CW-1:0]            o_mode,
    output logic [1:0]               o_src,
    output logic [N_CH*BTN_W-1:0]    o_btn,
    output logic [N_CH-1:0]          o_start,
    output logic [DATA_W-1:0]        o_disp_data,
    output logic                     o_mode_chg,
    output logic                     o_soft_rst
);

    localparam int AW = (AUTO_CYC > 1) ? $clog2(AUTO_CYC) : 1;
    localparam int TW = (TRIG_CYC > 1) ? $clog2(TRIG_CYC) : 1;
    localparam int RW = $clog2(SRST_CYC + 1);

    typedef enum logic [1:0] {
        ST_SW   = 2'b00,
        ST_UART = 2'b01,
        ST_AUTO = 2'b10
    } src_t;

    src_t                  state, state_nxt;
    logic [CW-1:0]         mode_nxt, mode_inc, sw_prev;
    logic                  auto_prev, auto_clr;
    logic [AW-1:0]         auto_cnt;
    logic [TW-1:0]         trig_cnt;
    logic [RW-1:0]         srst_cnt;
    logic [7:0]            cmd;
    logic                  sw_chg, auto_rise, auto_fall;
    logic                  cmd_digit, cmd_m, cmd_a, cmd_x;
    logic                  btn_hit, trig_fire;
    logic [1:0]            btn_sel;
    logic [BTN_W-1:0]      uart_btn;
    logic [N_CH*BTN_W-1:0] btn_nxt;
    logic [DATA_W-1:0]     disp_nxt;
    logic [N_CH-1:0]       start_nxt;

    // Lower-case letters fold onto their upper-case command.
    assign cmd = (rx_data >= 8'h61 && rx_data <= 8'h7a) ? rx_data - 8'h20 : rx_data;

    assign sw_chg    = (i_sw_mode != sw_prev);
    assign auto_rise = i_sw_auto & ~auto_prev;
    assign auto_fall = ~i_sw_auto & auto_prev;
    assign cmd_digit = rx_done && (cmd >= 8'h30) && (cmd <= 8'h39)
                       && ({4'b0, cmd[3:0]} < 8'(N_CH));
    assign cmd_m     = rx_done && (cmd == 8'h4d);
    assign cmd_a     = rx_done && (cmd == 8'h41);
    assign cmd_x     = rx_done && (cmd == 8'h58);
    assign mode_inc  = (o_mode == CW'(N_CH - 1)) ? '0 : o_mode + 1'b1;
    assign trig_fire = (trig_cnt == TW'(TRIG_CYC - 1));
    assign o_src     = state;
    assign o_soft_rst = (srst_cnt != '0);

    // Decode L/C/R/U into a button index; indices beyond BTN_W are dropped.
    always_comb begin
        btn_hit  = rx_done;
        btn_sel  = 2'd0;
        uart_btn = '0;
        case (cmd)
            8'h4c:   btn_sel = 2'd0;
            8'h43:   btn_sel = 2'd1;
            8'h52:   btn_sel = 2'd2;
            8'h55:   btn_sel = 2'd3;
            default: btn_hit = 1'b0;
        endcase
        for (int b = 0; b < BTN_W; b++)
            if (btn_hit && (b == int'(btn_sel))) uart_btn[b] = 1'b1;
    end

    // Source FSM next state and mode, priority: switch > auto edge > UART > auto step.
    always_comb begin
        state_nxt = state;
        mode_nxt  = o_mode;
        auto_clr  = 1'b0;
        if (sw_chg) begin
            state_nxt = ST_SW;
            mode_nxt  = i_sw_mode;
            auto_clr  = 1'b1;
        end else if (auto_rise) begin
            state_nxt = ST_AUTO;
            auto_clr  = 1'b1;
        end else if (auto_fall && state == ST_AUTO) begin
            state_nxt = ST_SW;
        end else if (cmd_a) begin
            if (state == ST_AUTO) begin
                state_nxt = ST_SW;
            end else begin
                state_nxt = ST_AUTO;
                auto_clr  = 1'b1;
            end
        end else if (cmd_digit || cmd_m) begin
            mode_nxt = cmd_digit ? cmd[CW-1:0] : mode_inc;
            if (state == ST_SW) state_nxt = ST_UART;
            auto_clr = 1'b1;
        end else if (state == ST_AUTO && auto_cnt == AW'(AUTO_CYC - 1)) begin
            mode_nxt = mode_inc;
            auto_clr = 1'b1;
        end
    end

    // Route buttons and display data of the currently active channel.
    always_comb begin
        btn_nxt   = '0;
        disp_nxt  = '0;
        start_nxt = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (o_mode == CW'(c)) begin
                btn_nxt[c*BTN_W +: BTN_W] = i_btn | uart_btn;
                disp_nxt = i_ch_data[c*DATA_W +: DATA_W];
                if (TRIG_MASK[c] && (o_mode_chg || trig_fire)) start_nxt[c] = 1'b1;
            end
        end
    end

    // FSM state, mode and edge-detect history.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_SW;
            o_mode     <= '0;
            o_mode_chg <= 1'b0;
            sw_prev    <= '0;
            auto_prev  <= 1'b0;
            auto_cnt   <= '0;
        end else begin
            state      <= state_nxt;
            o_mode     <= mode_nxt;
            o_mode_chg <= (mode_nxt != o_mode);
            sw_prev    <= i_sw_mode;
            auto_prev  <= i_sw_auto;
            auto_cnt   <= (auto_clr || state_nxt != ST_AUTO) ? '0 : auto_cnt + 1'b1;
        end
    end

    // Registered outputs and the trigger / soft-reset counters.
    // The trigger counter restarts right after o_mode_chg so periodic pulses
    // keep TRIG_CYC spacing from the immediate entry pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_btn       <= '0;
            o_disp_data <= '0;
            o_start     <= '0;
            trig_cnt    <= '0;
            srst_cnt    <= '0;
        end else begin
            o_btn       <= btn_nxt;
            o_disp_data <= disp_nxt;
            o_start     <= start_nxt;
            trig_cnt    <= (o_mode_chg || trig_fire) ? '0 : trig_cnt + 1'b1;
            if (cmd_x)
                srst_cnt <= RW'(SRST_CYC);
            else if (srst_cnt != '0)
                srst_cnt <= srst_cnt - 1'b1;
        end
    end

endmodule

// File: tb/tb_mode_hub.sv
// Testbench for mode_hub: directed scenarios plus a randomized run checked
// against a behavioural model of the mode/source/button/display rules.
module tb_mode_hub;

    localparam int N_CH     = 4;
    localparam int DATA_W   = 24;
    localparam int BTN_W    = 4;
    localparam int AUTO_CYC = 10;
    localparam int TRIG_CYC = 20;
    localparam int SRST_CYC = 16;

    // clock / reset block
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]               i_sw_mode = '0;
    logic                     i_sw_auto = 1'b0;
    logic [BTN_W-1:0]         i_btn = '0;
    logic                     rx_done = 1'b0;
    logic [7:0]               rx_data = '0;
    logic [N_CH*DATA_W-1:0]   i_ch_data = '0;
    logic [1:0]               o_mode;
    logic [1:0]               o_src;
    logic [N_CH*BTN_W-1:0]    o_btn;
    logic [N_CH-1:0]          o_start;
    logic [DATA_W-1:0]        o_disp_data;
    logic                     o_mode_chg;
    logic                     o_soft_rst;

    int errors = 0;
    int checks = 0;

    mode_hub #(
        .N_CH(N_CH), .DATA_W(DATA_W), .BTN_W(BTN_W), .AUTO_CYC(AUTO_CYC),
        .TRIG_CYC(TRIG_CYC), .TRIG_MASK(4'b1100), .SRST_CYC(SRST_CYC)
    ) dut (
        .clk(clk), .rst(rst), .i_sw_mode(i_sw_mode), .i_sw_auto(i_sw_auto),
        .i_btn(i_btn), .rx_done(rx_done), .rx_data(rx_data), .i_ch_data(i_ch_data),
        .o_mode(o_mode), .o_src(o_src), .o_btn(o_btn), .o_start(o_start),
        .o_disp_data(o_disp_data), .o_mode_chg(o_mode_chg), .o_soft_rst(o_soft_rst)
    );

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data = b;
        rx_done = 1'b1;
        tick();
        rx_done = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        i_ch_data = {$urandom(), $urandom(), $urandom()};
        i_btn = 4'hf;
        repeat (3) tick();
        i_btn = '0;
        checks++; if (o_mode !== 2'd0) begin errors++; $display("FAIL reset_mode: got %0d want 0", o_mode); end
        checks++; if (o_src !== 2'b00) begin errors++; $display("FAIL reset_src: got %b want 00", o_src); end
        checks++; if (o_btn !== '0) begin errors++; $display("FAIL reset_btn: got %h want 0", o_btn); end
        checks++; if (o_start !== '0) begin errors++; $display("FAIL reset_start: got %b want 0", o_start); end
        checks++; if (o_disp_data !== '0) begin errors++; $display("FAIL reset_disp: got %h want 0", o_disp_data); end
        checks++; if (o_mode_chg !== 1'b0) begin errors++; $display("FAIL reset_chg: got %b want 0", o_mode_chg); end
        checks++; if (o_soft_rst !== 1'b0) begin errors++; $display("FAIL reset_srst: got %b want 0", o_soft_rst); end
    endtask

    task automatic test_sw_mode();
        int n_chg;
        rst = 1'b1;
        tick();
        i_sw_mode = 2'd2;
        tick();
        checks++; if (o_mode !== 2'd2) begin errors++; $display("FAIL sw_mode: got %0d want 2", o_mode); end
        checks++; if (o_src !== 2'b00) begin errors++; $display("FAIL sw_src: got %b want 00", o_src); end
        checks++; if (o_mode_chg !== 1'b1) begin errors++; $display("FAIL sw_chg: got %b want 1", o_mode_chg); end
        n_chg = 0;
        for (int i = 0; i < 5; i++) begin
            i_ch_data = {$urandom(), $urandom(), $urandom()};
            tick();
            if (o_mode_chg) n_chg++;
        end
        checks++; if (n_chg != 0) begin errors++; $display("FAIL sw_chg_once: extra pulses %0d want 0", n_chg); end
        checks++; if (o_disp_data !== i_ch_data[2*DATA_W +: DATA_W]) begin
            errors++; $display("FAIL sw_disp: got %h want %h", o_disp_data, i_ch_data[2*DATA_W +: DATA_W]);
        end
    endtask

    task automatic test_uart_mode();
        send_byte(8'h33);  // '3'
        checks++; if (o_mode !== 2'd3) begin errors++; $display("FAIL uart3_mode: got %0d want 3", o_mode); end
        checks++; if (o_src !== 2'b01) begin errors++; $display("FAIL uart3_src: got %b want 01", o_src); end
        checks++; if (o_mode_chg !== 1'b1) begin errors++; $display("FAIL uart3_chg: got %b want 1", o_mode_chg); end
        tick();
        checks++; if (o_mode_chg !== 1'b0) begin errors++; $display("FAIL uart3_chg_end: got %b want 0", o_mode_chg); end
        send_byte(8'h6d);  // 'm' wraps 3 -> 0
        checks++; if (o_mode !== 2'd0) begin errors++; $display("FAIL uart_m_wrap: got %0d want 0", o_mode); end
        checks++; if (o_mode_chg !== 1'b1) begin errors++; $display("FAIL uart_m_chg: got %b want 1", o_mode_chg); end
        send_byte(8'h37);  // '7' out of range
        checks++; if (o_mode !== 2'd0) begin errors++; $display("FAIL uart7_mode: got %0d want 0", o_mode); end
        checks++; if (o_mode_chg !== 1'b0) begin errors++; $display("FAIL uart7_chg: got %b want 0", o_mode_chg); end
        send_byte(8'h30);  // '0' selects current mode
        checks++; if (o_mode_chg !== 1'b0) begin errors++; $display("FAIL uart_same_chg: got %b want 0", o_mode_chg); end
        checks++; if (o_src !== 2'b01) begin errors++; $display("FAIL uart_same_src: got %b want 01", o_src); end
    endtask

    task automatic test_auto();
        int want_mode;
        logic want_chg;
        i_sw_auto = 1'b1;
        tick();
        checks++; if (o_src !== 2'b10) begin errors++; $display("FAIL auto_src: got %b want 10", o_src); end
        checks++; if (o_mode_chg !== 1'b0) begin errors++; $display("FAIL auto_entry_chg: got %b want 0", o_mode_chg); end
        for (int i = 1; i <= 40; i++) begin
            tick();
            want_mode = (i / AUTO_CYC) % N_CH;
            want_chg  = (i % AUTO_CYC == 0);
            checks++; if (o_mode !== 2'(want_mode)) begin errors++; $display("FAIL auto_step[%0d]: got %0d want %0d", i, o_mode, want_mode); end
            checks++; if (o_mode_chg !== want_chg) begin errors++; $display("FAIL auto_chg[%0d]: got %b want %b", i, o_mode_chg, want_chg); end
        end
        i_sw_auto = 1'b0;
        tick();
        checks++; if (o_src !== 2'b00) begin errors++; $display("FAIL auto_fall_src: got %b want 00", o_src); end
        checks++; if (o_mode !== 2'd0) begin errors++; $display("FAIL auto_fall_mode: got %0d want 0", o_mode); end
    endtask

    task automatic test_btn();
        send_byte(8'h32);  // '2'
        i_btn = 4'b0001;
        tick();
        i_btn = '0;
        checks++; if (o_btn !== 16'h0100) begin errors++; $display("FAIL btn_hw: got %h want 0100", o_btn); end
        tick();
        checks++; if (o_btn !== 16'h0000) begin errors++; $display("FAIL btn_hw_end: got %h want 0000", o_btn); end
        i_btn = 4'b0001;
        send_byte(8'h52);  // 'R' together with hardware bit 0
        i_btn = '0;
        checks++; if (o_btn !== 16'h0500) begin errors++; $display("FAIL btn_or: got %h want 0500", o_btn); end
        send_byte(8'h75);  // 'u'
        checks++; if (o_btn !== 16'h0800) begin errors++; $display("FAIL btn_u: got %h want 0800", o_btn); end
    endtask

    task automatic test_trigger();
        logic [3:0] want;
        int n_hi;
        send_byte(8'h33);  // '3' -> masked channel
        checks++; if (o_mode_chg !== 1'b1) begin errors++; $display("FAIL trig_entry_chg: got %b want 1", o_mode_chg); end
        for (int i = 1; i <= 41; i++) begin
            tick();
            want = (i == 1 || i == 1 + TRIG_CYC || i == 1 + 2*TRIG_CYC) ? 4'b1000 : 4'b0000;
            checks++; if (o_start !== want) begin errors++; $display("FAIL trig_start[%0d]: got %b want %b", i, o_start, want); end
        end
        send_byte(8'h31);  // '1' -> unmasked channel
        n_hi = 0;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (o_start != '0) n_hi++;
        end
        checks++; if (n_hi != 0) begin errors++; $display("FAIL trig_unmasked: pulses %0d want 0", n_hi); end
    endtask

    task automatic test_soft_rst();
        int n_hi;
        send_byte(8'h78);  // 'x'
        n_hi = 0;
        for (int i = 0; i < 40 && o_soft_rst; i++) begin
            n_hi++;
            tick();
        end
        checks++; if (n_hi != SRST_CYC) begin errors++; $display("FAIL srst_len: got %0d want %0d", n_hi, SRST_CYC); end
        send_byte(8'h58);  // 'X'
        repeat (4) tick();
        checks++; if (o_soft_rst !== 1'b1) begin errors++; $display("FAIL srst_active: got %b want 1", o_soft_rst); end
        send_byte(8'h78);  // restart while active
        n_hi = 0;
        for (int i = 0; i < 40 && o_soft_rst; i++) begin
            n_hi++;
            tick();
        end
        checks++; if (n_hi != SRST_CYC) begin errors++; $display("FAIL srst_restart: got %0d want %0d", n_hi, SRST_CYC); end
        // reset in the middle of a soft-reset and a button pulse
        send_byte(8'h78);
        i_btn = 4'b0010;
        tick();
        i_btn = '0;
        checks++; if (o_btn !== 16'h0020) begin errors++; $display("FAIL pre_rst_btn: got %h want 0020", o_btn); end
        rst = 1'b0;
        #1;
        checks++; if (o_soft_rst !== 1'b0) begin errors++; $display("FAIL rst_abort_srst: got %b want 0", o_soft_rst); end
        checks++; if (o_btn !== '0) begin errors++; $display("FAIL rst_abort_btn: got %h want 0", o_btn); end
        checks++; if (o_mode !== 2'd0) begin errors++; $display("FAIL rst_abort_mode: got %0d want 0", o_mode); end
    endtask

    // scoreboard: behavioural model of source/mode/button/display rules
    task automatic test_random();
        logic [7:0] pool [16] = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h37, 8'h39, 8'h6d, 8'h4d,
                                  8'h61, 8'h41, 8'h4c, 8'h63, 8'h72, 8'h55, 8'h7a, 8'h3f};
        logic [15:0]       exp_q[$];
        logic [15:0]       exp_btn;
        logic [DATA_W-1:0] exp_disp;
        logic [3:0]        ub, btn_v;
        logic [7:0]        b, c;
        logic              v, exp_chg;
        int m_mode, m_src, m_age, m_swp, old, sw;
        rst = 1'b0;
        i_sw_mode = '0;
        i_sw_auto = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        m_mode = 0; m_src = 0; m_age = 0; m_swp = 0; sw = 0;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 11) == 0) sw = $urandom_range(0, 3);
            v = ($urandom_range(0, 3) == 0);
            b = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255)) : pool[$urandom_range(0, 15)];
            btn_v = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
            i_sw_mode = 2'(sw); rx_done = v; rx_data = b; i_btn = btn_v;
            i_ch_data = {$urandom(), $urandom(), $urandom()};
            c = (b >= 8'h61 && b <= 8'h7a) ? b - 8'h20 : b;
            ub = 4'h0;
            if (v && c == 8'h4c) ub = 4'b0001;
            if (v && c == 8'h43) ub = 4'b0010;
            if (v && c == 8'h52) ub = 4'b0100;
            if (v && c == 8'h55) ub = 4'b1000;
            exp_q.push_back(16'(btn_v | ub) << (m_mode * BTN_W));
            exp_disp = i_ch_data[m_mode*DATA_W +: DATA_W];
            old = m_mode;
            if (sw != m_swp) begin
                m_src = 0; m_mode = sw; m_age = 0;
            end else if (v && c == 8'h41) begin
                if (m_src == 2) m_src = 0;
                else begin m_src = 2; m_age = 0; end
            end else if (v && ((c >= 8'h30 && c <= 8'h39 && int'(c) - 48 < N_CH) || c == 8'h4d)) begin
                m_mode = (c == 8'h4d) ? (m_mode + 1) % N_CH : int'(c) - 48;
                if (m_src == 0) m_src = 1;
                m_age = 0;
            end else if (m_src == 2) begin
                m_age++;
                if (m_age == AUTO_CYC) begin m_mode = (m_mode + 1) % N_CH; m_age = 0; end
            end
            m_swp = sw;
            exp_chg = (m_mode != old);
            tick();
            rx_done = 1'b0;
            exp_btn = exp_q.pop_front();
            checks++; if (o_mode !== 2'(m_mode)) begin errors++; $display("FAIL rnd_mode[%0d]: got %0d want %0d", n, o_mode, m_mode); end
            checks++; if (o_src !== 2'(m_src)) begin errors++; $display("FAIL rnd_src[%0d]: got %b want %0d", n, o_src, m_src); end
            checks++; if (o_mode_chg !== exp_chg) begin errors++; $display("FAIL rnd_chg[%0d]: got %b want %b", n, o_mode_chg, exp_chg); end
            checks++; if (o_btn !== exp_btn) begin errors++; $display("FAIL rnd_btn[%0d]: got %h want %h", n, o_btn, exp_btn); end
            checks++; if (o_disp_data !== exp_disp) begin errors++; $display("FAIL rnd_disp[%0d]: got %h want %h", n, o_disp_data, exp_disp); end
        end
        i_btn = '0;
    endtask

    initial begin
        test_reset();
        test_sw_mode();
        test_uart_mode();
        test_auto();
        test_btn();
        test_trigger();
        test_soft_rst();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mode_hub.md
MODE_HUB -- requirements
Module: mode_hub

Parameters
REQ-001 The block SHALL take parameter N_CH, default 4: number of display/function channels, range 2..8.
REQ-002 The block SHALL take parameter DATA_W, default 24: width of each channel's display word.
REQ-003 The block SHALL take parameter BTN_W, default 4: number of button lines per channel.
REQ-004 The block SHALL take parameter AUTO_CYC, default 300_000_000: clock cycles per auto-scroll step.
REQ-005 The block SHALL take parameter TRIG_CYC, default 100_000_000: clock cycles between periodic sensor start pulses.
REQ-006 The block SHALL take parameter TRIG_MASK, default 4'b1100: bit c set means channel c receives periodic start pulses.
REQ-007 The block SHALL take parameter SRST_CYC, default 16: soft-reset pulse length in cycles.

Interface (CW = $clog2(N_CH))
REQ-008 clk  in  1  system clock, single clock domain.
REQ-009 rst  in  1  asynchronous, active-low reset.
REQ-010 i_sw_mode  in  CW  hardware mode switches, synchronised externally.
REQ-011 i_sw_auto  in  1  level; 1 = auto-scroll requested.
REQ-012 i_btn  in  BTN_W  debounced single-cycle button pulses.
REQ-013 rx_done  in  1  one-cycle strobe qualifying rx_data.
REQ-014 rx_data  in  8  received UART byte.
REQ-015 i_ch_data  in  N_CH*DATA_W  channel c occupies bits [c*DATA_W +: DATA_W].
REQ-016 o_mode  out  CW  active channel index.
REQ-017 o_src  out  2  mode source: 00 SW, 01 UART, 10 AUTO.
REQ-018 o_btn  out  N_CH*BTN_W  routed button pulses, slice per channel.
REQ-019 o_start  out  N_CH  one-cycle sensor start pulses.
REQ-020 o_disp_data  out  DATA_W  registered display word.
REQ-021 o_mode_chg  out  1  one-cycle pulse on any o_mode change.
REQ-022 o_soft_rst  out  1  active-high soft-reset request.

Function
REQ-023 The source FSM SHALL use states SW, UART and AUTO.
REQ-024 The FSM SHALL reset to state SW.
REQ-025 SW->UART SHALL occur on an accepted UART mode command.
REQ-026 Any state SHALL go to SW on a change of i_sw_mode versus its previous-cycle value; the mode takes the new switch value.
REQ-027 Any state SHALL go to AUTO on a rising edge of i_sw_auto or on UART 'A' while not in AUTO.
REQ-028 AUTO->SW SHALL occur on a falling edge of i_sw_auto or on UART 'A' while in AUTO.
REQ-029 UART command '0'..'9' (0x30+k) with k < N_CH SHALL set o_mode = k; k >= N_CH SHALL be ignored.
REQ-030 UART 'M' SHALL advance o_mode by 1, wrapping N_CH-1 -> 0.
REQ-031 UART 'L', 'C', 'R', 'U' SHALL produce a one-cycle pulse on o_btn bit 0, 1, 2, 3 respectively of the active channel; bits >= BTN_W SHALL be ignored.
REQ-032 UART 'X' SHALL assert o_soft_rst for exactly SRST_CYC cycles; an 'X' received while the pulse is active SHALL restart the count.
REQ-033 Lower-case letters SHALL be accepted as the matching upper-case command; all other bytes SHALL be ignored.
REQ-034 Simultaneous events SHALL be resolved by priority: switch change > auto edge > UART command.
REQ-035 In AUTO, a counter SHALL advance o_mode (with wrap) every AUTO_CYC cycles.
REQ-036 The AUTO counter SHALL clear on entry to AUTO and on any manual mode change.
REQ-037 i_btn SHALL be routed to the active channel slice only, with 1-cycle registered latency; all other slices SHALL be 0.
REQ-038 A hardware and a UART button pulse in the same cycle SHALL be OR-ed.
REQ-039 A free-running counter SHALL pulse o_start[o_mode] every TRIG_CYC cycles only when TRIG_MASK[o_mode] = 1.
REQ-040 On a mode change the trigger counter SHALL clear, and a new TRIG_MASK channel SHALL get one immediate start pulse on the cycle after o_mode_chg.
REQ-041 o_disp_data SHALL equal the active slice of i_ch_data with 1-cycle latency.
REQ-042 o_mode_chg SHALL pulse in the same cycle o_mode updates; a command selecting the current mode SHALL not pulse.

Reset
REQ-043 While rst = 0, the block SHALL hold o_mode = 0, o_src = 00, o_btn = 0, o_start = 0, o_disp_data = 0, o_mode_chg = 0, o_soft_rst = 0, with all counters at 0.
REQ-044 Reset mid-pulse SHALL abort o_soft_rst and any start or button pulse immediately.
REQ-045 o_soft_rst SHALL NOT reset this block.

Verification
REQ-046 Scenario: rst low, then release; i_sw_mode = 2 -> o_mode 2, o_src 00, o_mode_chg pulses once.
REQ-047 Scenario: rx '3' then 'm' (N_CH = 4) -> o_mode 3 then 0, o_src 01, two o_mode_chg pulses.
REQ-048 Scenario: rx '7' with N_CH = 4 -> no change, no pulse.
REQ-049 Scenario: i_sw_auto rising edge with AUTO_CYC = 10 -> o_mode steps every 10 cycles, 3 -> 0 wrap observed; falling edge -> o_src 00.
REQ-050 Scenario: mode 2, i_btn = 4'b0001 -> o_btn[8] high 1 cycle, all other bits 0; rx 'R' in the same cycle -> o_btn[8] and o_btn[10] high.
REQ-051 Scenario: mode 3 with TRIG_CYC = 20 -> o_start[3] pulses the cycle after entry, then every 20 cycles; rx 'x' -> o_soft_rst high 16 cycles.
